// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed-latency read handshake (IDLE/BUSY/DONE).
// Optional macro DMEM_ALIGN_CHECK_EN enables misaligned-access faulting.
module data_mem_responder #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mem_readEn,
  input  logic [READ_ADDR_SIZE-1:0] mem_readAddr,
  input  logic                      mem_writeEn,
  input  logic [READ_ADDR_SIZE-1:0] mem_writeAddr,
  input  logic [XLEN-1:0]           mem_writeData,
  output logic                      mem_readFin,
  output logic [XLEN-1:0]           mem_radData,
  output logic                      mem_fault
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   rd_idx_q;
  logic            rd_mis_q;
  logic [XLEN-1:0] mem [MEM_DEPTH];

  logic [AW-1:0]   rd_idx_now;
  logic [AW-1:0]   wr_idx;
  logic            rd_mis_now;
  logic            wr_mis;
  logic            wr_en;
  logic            done_entry;
  logic            done_mis;
  logic [AW-1:0]   done_idx;
  logic            unused_addr;

  // Upper address bits wrap modulo MEM_DEPTH; byte-lane bits only matter for alignment.
  assign rd_idx_now  = mem_readAddr[AW+1:2];
  assign wr_idx      = mem_writeAddr[AW+1:2];
  assign unused_addr = ^{mem_readAddr, mem_writeAddr};

`ifdef DMEM_ALIGN_CHECK_EN
  assign rd_mis_now = |mem_readAddr[1:0];
  assign wr_mis     = |mem_writeAddr[1:0];
`else
  assign rd_mis_now = 1'b0;
  assign wr_mis     = 1'b0;
`endif

  assign wr_en = mem_writeEn && !rst && !wr_mis;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    done_entry = 1'b0;
    done_mis   = rd_mis_q;
    done_idx   = rd_idx_q;
    if (state == IDLE) begin
      done_entry = mem_readEn && (READ_LATENCY == 1);
      done_mis   = rd_mis_now;
      done_idx   = rd_idx_now;
    end else if (state == BUSY) begin
      done_entry = mem_readEn && (cnt == CW'(1));
    end
  end

  // NOTE: the memory array has no reset; contents survive rst and only the write is blocked.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= mem_writeData;
  end

  // NOTE: non-blocking reads sample mem before this edge's write lands, giving read-old.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mem_readFin <= 1'b0;
      mem_radData <= '0;
    end else begin
      mem_readFin <= 1'b0;
      if (done_entry) begin
        mem_readFin <= 1'b1;
        mem_radData <= done_mis ? '0 : mem[done_idx];
      end
      case (state)
        IDLE: begin
          if (mem_readEn) begin
            rd_idx_q <= rd_idx_now;
            rd_mis_q <= rd_mis_now;
            if (READ_LATENCY == 1) begin
              state <= DONE;
            end else begin
              cnt   <= CW'(READ_LATENCY - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!mem_readEn) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            if (done_entry) state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= (done_entry && done_mis) || (mem_writeEn && wr_mis);
  end

  assign mem_fault = fault_q;
`else
  assign mem_fault = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder (latency-2 main instance, latency-1 side instance).
module tb_data_mem_responder;

  typedef struct {
    logic [31:0] data;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en = 1'b0, rd_en1 = 1'b0;
  logic [31:0] rd_addr = '0, rd_addr1 = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wr_addr = '0, wr_data = '0;
  logic        fin, fin1, fault, fault1;
  logic [31:0] rdata, rdata1;

  logic [31:0] model [1024];
  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.READ_LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .mem_readEn(rd_en), .mem_readAddr(rd_addr),
    .mem_writeEn(wr_en), .mem_writeAddr(wr_addr), .mem_writeData(wr_data),
    .mem_readFin(fin), .mem_radData(rdata), .mem_fault(fault)
  );

  data_mem_responder #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_readEn(rd_en1), .mem_readAddr(rd_addr1),
    .mem_writeEn(wr_en), .mem_writeAddr(wr_addr), .mem_writeData(wr_data),
    .mem_readFin(fin1), .mem_radData(rdata1), .mem_fault(fault1)
  );

  function automatic logic [9:0] widx(input logic [31:0] a);
    return a[11:2];
  endfunction

  function automatic logic mis(input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return |a[1:0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    step();
    wr_en = 1'b0;
    if (!mis(addr)) model[widx(addr)] = data;
    check({tag, " wr_fault"}, {31'd0, fault}, {31'd0, mis(addr)});
  endtask

  // Issue a read; optionally write the same word at accept, and/or write it during the readFin cycle.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input bit acc_wr, input logic [31:0] acc_data,
                         input bit fin_wr, input logic [31:0] fin_data);
    exp_t e;
    int   n;
    rd_en = 1'b1; rd_addr = addr;
    if (acc_wr) begin
      wr_en = 1'b1; wr_addr = addr; wr_data = acc_data;
      if (!mis(addr)) model[widx(addr)] = acc_data;
    end
    e.data  = mis(addr) ? 32'd0 : model[widx(addr)];
    e.fault = mis(addr);
    sb.push_back(e);
    n = 0;
    do begin
      step();
      wr_en = 1'b0;
      n++;
    end while (!fin && n < 8);
    check({tag, " latency"}, n, 2);
    e = sb.pop_front();
    check({tag, " data"}, rdata, e.data);
    check({tag, " fault"}, {31'd0, fault}, {31'd0, e.fault});
    rd_en = 1'b0;
    if (fin_wr) begin
      wr_en = 1'b1; wr_addr = addr; wr_data = fin_data;
    end
    step();
    wr_en = 1'b0;
    if (fin_wr && !mis(addr)) model[widx(addr)] = fin_data;
    check({tag, " pulse"}, {31'd0, fin}, 32'd0);
    check({tag, " hold"}, rdata, e.data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step();
    step();
    check("rst fin", {31'd0, fin}, 32'd0);
    check("rst rdata", rdata, 32'd0);
    check("rst fault", {31'd0, fault}, 32'd0);
    check("rst fin1", {31'd0, fin1}, 32'd0);
    check("rst rdata1", rdata1, 32'd0);
    rst = 1'b0;
    step();

    do_write("w10", 32'h10, 32'hDEADBEEF);
    do_read("r10", 32'h10, 1'b0, 32'd0, 1'b0, 32'd0);

    do_write("w30", 32'h30, 32'h11);
    do_read("r30 old", 32'h30, 1'b0, 32'd0, 1'b1, 32'h22);
    do_read("r30 new", 32'h30, 1'b0, 32'd0, 1'b0, 32'd0);

    do_write("w0", 32'h0, 32'hA5);
    do_read("r1000 wrap", 32'h1000, 1'b0, 32'd0, 1'b0, 32'd0);

    do_write("w40", 32'h40, 32'h77);
    rst = 1'b1; wr_en = 1'b1; wr_addr = 32'h40; wr_data = 32'hBAD0BAD0;
    step();
    rst = 1'b0; wr_en = 1'b0;
    do_read("r40 rstwr", 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);

    do_read("r50 accwr", 32'h50, 1'b1, 32'hCAFE0050, 1'b0, 32'd0);

    // Abort by dropping readEn while BUSY
    do_write("w60", 32'h60, 32'h66);
    rd_en = 1'b1; rd_addr = 32'h60;
    step();
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("abort fin", {31'd0, fin}, 32'd0);
    end
    check("abort hold", rdata, 32'hCAFE0050);

    // Abort by reset while BUSY
    rd_en = 1'b1; rd_addr = 32'h60;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; rd_en = 1'b0;
    check("rstabort fin", {31'd0, fin}, 32'd0);
    check("rstabort rdata", rdata, 32'd0);
    step();
    check("rstabort idle", {31'd0, fin}, 32'd0);
    do_read("r60 after", 32'h60, 1'b0, 32'd0, 1'b0, 32'd0);

    // Byte-lane bits: ignored by default, faulting when the alignment check is built in
    do_read("r13 mis", 32'h13, 1'b0, 32'd0, 1'b0, 32'd0);
    do_write("w41 mis", 32'h41, 32'h99);
    step();
    check("w41 fault clr", {31'd0, fault}, 32'd0);
    do_read("r40 after", 32'h40, 1'b0, 32'd0, 1'b0, 32'd0);

    // Latency-1 instance
    do_write("w20", 32'h20, 32'h12345678);
    rd_en1 = 1'b1; rd_addr1 = 32'h20;
    step();
    check("l1 fin", {31'd0, fin1}, 32'd1);
    check("l1 data", rdata1, 32'h12345678);
    rd_en1 = 1'b0;
    step();
    check("l1 pulse", {31'd0, fin1}, 32'd0);
    check("l1 hold", rdata1, 32'h12345678);

    for (int i = 0; i < 4; i++) do_write("wrnd", 32'h200 + 32'(i) * 4, $urandom);
    for (int i = 3; i >= 0; i--) do_read("rrnd", 32'h200 + 32'(i) * 4, 1'b0, 32'd0, 1'b0, 32'd0);

    check("sb empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
